// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared constants, state type and helpers for the HS byte aligner
package dphy_pkg;

    localparam logic [7:0] SOT_SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        HUNT,
        ALIGNED,
        FAIL
    } align_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dphy_sync_detect.sv
// rtl/dphy_sync_detect.sv - SoT sync search over the 2-byte window; SOT_SINGLE_BIT_TOL_EN adds 1-bit tolerance
module dphy_sync_detect
    import dphy_pkg::*;
(
    input  logic [14:0] w,
    output logic        match,
    output logic [2:0]  k,
    output logic        one_bit_err
);

    always_comb begin
        match       = 1'b0;
        k           = 3'd0;
        one_bit_err = 1'b0;
        // Descending scan so the lowest matching offset is the one left standing.
        for (int i = 7; i >= 0; i--) begin
            if (w[i +: 8] == SOT_SYNC_BYTE) begin
                match = 1'b1;
                k     = 3'(i);
            end
        end
`ifdef SOT_SINGLE_BIT_TOL_EN
        // Near misses only count when no exact sync exists at any offset.
        if (!match) begin
            for (int i = 7; i >= 0; i--) begin
                if (popcount8(w[i +: 8] ^ SOT_SYNC_BYTE) == 4'd1) begin
                    match       = 1'b1;
                    k           = 3'(i);
                    one_bit_err = 1'b1;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/dphy_hs_byte_align.sv
// rtl/dphy_hs_byte_align.sv - D-PHY data-lane byte aligner; SOT_SINGLE_BIT_TOL_EN enables 1-bit sync tolerance
module dphy_hs_byte_align
    import dphy_pkg::*;
#(
    parameter int SETTLE_BYTES = 4,
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] byte_i,
    input  logic       hs_rx_en_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       sync_o,
    output logic [2:0] offset_o,
    output logic       err_sot_sync_o,
    output logic       err_sot_o
);

    align_state_t state, next_state;
    logic [7:0]   cnt, cnt_next;
    logic [7:0]   byte_d;
    logic [14:0]  w;
    logic         match;
    logic [2:0]   match_k;
    logic         one_bit_err;
    logic         sync_set;
    logic         timeout_set;

    // Bit 15 of the full window is never the start of any candidate.
    assign w = {byte_i[6:0], byte_d};

    dphy_sync_detect u_sync_detect (
        .w           (w),
        .match       (match),
        .k           (match_k),
        .one_bit_err (one_bit_err)
    );

    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        sync_set    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (hs_rx_en_i) begin
                    next_state = SETTLE;
                    cnt_next   = 8'd0;
                end
            end
            SETTLE: begin
                if (cnt == 8'(SETTLE_BYTES)) begin
                    next_state = HUNT;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            HUNT: begin
                if (match) begin
                    next_state = ALIGNED;
                    sync_set   = hs_rx_en_i;
                end else if (cnt == 8'(SYNC_TIMEOUT - 1)) begin
                    next_state  = FAIL;
                    timeout_set = hs_rx_en_i;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ALIGNED: next_state = ALIGNED;
            FAIL:    next_state = FAIL;
            default: next_state = IDLE;
        endcase
        // Leaving HS mode overrides everything, including a same-cycle match.
        if (!hs_rx_en_i) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            byte_d         <= 8'd0;
            byte_o         <= 8'd0;
            valid_o        <= 1'b0;
            sync_o         <= 1'b0;
            offset_o       <= 3'd0;
            err_sot_sync_o <= 1'b0;
            err_sot_o      <= 1'b0;
        end else begin
            state          <= next_state;
            cnt            <= cnt_next;
            byte_d         <= byte_i;
            sync_o         <= sync_set;
            err_sot_sync_o <= timeout_set;
            err_sot_o      <= sync_set & one_bit_err;
            if (sync_set) begin
                offset_o <= match_k;
            end
            if (state == ALIGNED && hs_rx_en_i) begin
                byte_o  <= w[offset_o +: 8];
                valid_o <= 1'b1;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
